// File: rtl/riscv_cfg_loader.sv
// Shadow/active configuration loader for the OoO engine and branch predictor.
// Fields are written into a shadow set, checked one per cycle, then published atomically.
module riscv_cfg_loader #(
   parameter int FIELD_W    = 16,
   parameter int NUM_FIELDS = 14
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_valid_i,
   output logic                          wr_ready_o,
   input  logic [3:0]                    wr_addr_i,
   input  logic [FIELD_W-1:0]            wr_data_i,
   input  logic                          commit_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          error_o,
   output logic [3:0]                    err_field_o,
   output logic                          cfg_valid_o,
   output logic [NUM_FIELDS*FIELD_W-1:0] cfg_o,
   output logic [1:0]                    dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_COMMIT = 2'd2
   } state_e;

   localparam logic [3:0]         LAST_IDX   = 4'(NUM_FIELDS - 1);
   localparam logic [FIELD_W-1:0] TYPE_LIMIT = FIELD_W'(4);

   state_e             state_q;
   logic [3:0]         idx_q;
   logic [3:0]         idx_d;
   logic               done_q;
   logic               error_q;
   logic [3:0]         err_field_q;
   logic               cfg_valid_q;
   logic [FIELD_W-1:0] shadow_q [NUM_FIELDS];
   logic [FIELD_W-1:0] active_q [NUM_FIELDS];
   logic [FIELD_W-1:0] cur_field;
   logic               field_ok;

   // Write handshake: a write is taken on any edge where wr_valid_i && wr_ready_o;
   // wr_ready_o is high only in IDLE, and out-of-range addresses are taken but dropped.
   assign wr_ready_o  = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

   assign idx_d     = idx_q + 4'd1;
   assign cur_field = shadow_q[idx_q];
   // The last field is the predictor type selector; every other field is a nonzero size.
   assign field_ok  = (idx_q == LAST_IDX) ? (cur_field < TYPE_LIMIT) : (cur_field != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_field_q <= '0;
         cfg_valid_q <= 1'b0;
         for (int k = 0; k < NUM_FIELDS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (wr_valid_i && (wr_addr_i <= LAST_IDX)) begin
                  shadow_q[wr_addr_i] <= wr_data_i;
               end
               if (commit_i) begin
                  state_q     <= S_CHECK;
                  idx_q       <= '0;
                  error_q     <= 1'b0;
                  err_field_q <= '0;
               end
            end
            S_CHECK: begin
               if (!field_ok) begin
                  error_q     <= 1'b1;
                  err_field_q <= idx_q;
                  done_q      <= 1'b1;
                  state_q     <= S_IDLE;
               end else if (idx_q == LAST_IDX) begin
                  state_q <= S_COMMIT;
               end else begin
                  idx_q <= idx_d;
               end
            end
            S_COMMIT: begin
               for (int k = 0; k < NUM_FIELDS; k++) begin
                  active_q[k] <= shadow_q[k];
               end
               cfg_valid_q <= 1'b1;
               done_q      <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign done_o      = done_q;
   assign error_o     = error_q;
   assign err_field_o = err_field_q;
   assign cfg_valid_o = cfg_valid_q;

   always_comb begin
      cfg_o = '0;
      for (int k = 0; k < NUM_FIELDS; k++) begin
         cfg_o[k*FIELD_W +: FIELD_W] = active_q[k];
      end
   end

endmodule

// File: tb/tb_riscv_cfg_loader.sv
// Bench for riscv_cfg_loader: directed test-plan sequences plus random traffic,
// all outputs compared every cycle against a countdown-based behavioural model.
module tb_riscv_cfg_loader;

   localparam int FW = 16;
   localparam int NF = 14;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [3:0]     wr_addr = '0;
   logic [FW-1:0]  wr_data = '0;
   logic           commit = 1'b0;
   logic           busy;
   logic           done;
   logic           error;
   logic [3:0]     err_field;
   logic           cfg_valid;
   logic [NF*FW-1:0] cfg;
   logic [1:0]     dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   riscv_cfg_loader #(.FIELD_W(FW), .NUM_FIELDS(NF)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .commit_i    (commit),
      .busy_o      (busy),
      .done_o      (done),
      .error_o     (error),
      .err_field_o (err_field),
      .cfg_valid_o (cfg_valid),
      .cfg_o       (cfg),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // A commit occupies a fixed number of busy cycles decided at the commit edge:
   // first failing field k -> k+1 cycles, all pass -> 15 cycles.
   logic [FW-1:0] m_shadow [NF];
   logic [FW-1:0] m_active [NF];
   int            m_left = 0;
   int            m_k = 0;
   bit            m_done = 0;
   bit            m_error = 0;
   int            m_err_field = 0;
   bit            m_cfg_valid = 0;

   function automatic int first_fail();
      for (int i = 0; i < NF; i++) begin
         if (i == NF - 1) begin
            if (m_shadow[i] >= 4) return i;
         end else if (m_shadow[i] == 0) begin
            return i;
         end
      end
      return NF;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NF; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_left = 0;
      m_k = 0;
      m_done = 0;
      m_error = 0;
      m_err_field = 0;
      m_cfg_valid = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         m_done = 0;
         if (m_left == 0) begin
            if (wr_valid && (int'(wr_addr) < NF)) m_shadow[wr_addr] = wr_data;
            if (commit) begin
               m_error = 0;
               m_err_field = 0;
               m_k = first_fail();
               m_left = (m_k == NF) ? 15 : m_k + 1;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1;
               if (m_k == NF) begin
                  m_active = m_shadow;
                  m_cfg_valid = 1;
               end else begin
                  m_error = 1;
                  m_err_field = m_k;
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [NF*FW-1:0] model_cfg();
      logic [NF*FW-1:0] v;
      v = '0;
      for (int i = 0; i < NF; i++) v[i*FW +: FW] = m_active[i];
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy",      busy,      m_left != 0);
         chk("wr_ready",  wr_ready,  m_left == 0);
         chk("done",      done,      m_done);
         chk("error",     error,     m_error);
         chk("err_field", err_field, m_err_field);
         chk("cfg_valid", cfg_valid, m_cfg_valid);
         chk("cfg",       cfg,       model_cfg());
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic write_field(input int addr, input int data);
      wr_valid = 1'b1;
      wr_addr  = 4'(addr);
      wr_data  = FW'(data);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic commit_wait(input bit noisy, output int cyc, output int bcnt);
      commit = 1'b1;
      @(posedge clk);
      #1;
      commit = 1'b0;
      cyc = 0;
      bcnt = busy ? 1 : 0;
      while (cyc < 40) begin
         if (noisy) begin
            chk("ready_low_busy", wr_ready, 1'b0);
            wr_valid = 1'b1;
            wr_addr  = 4'($urandom_range(0, NF - 1));
            wr_data  = '0;
            commit   = 1'b1;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (done) break;
         if (busy) bcnt++;
      end
      wr_valid = 1'b0;
      commit = 1'b0;
      if (cyc >= 40) chk("done_timeout", 1'b0, 1'b1);
   endtask

   function automatic int field(input int k);
      return int'(cfg[k*FW +: FW]);
   endfunction

   int preset [NF] = '{16, 8, 64, 2, 1, 1, 32, 256, 512, 512, 512, 8, 8, 2};

   initial begin
      int cyc;
      int bcnt;
      logic [3:0] a;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_ready",  wr_ready,  1'b1);
      chk("rst_busy",      busy,      1'b0);
      chk("rst_done",      done,      1'b0);
      chk("rst_error",     error,     1'b0);
      chk("rst_err_field", err_field, 4'd0);
      chk("rst_cfg_valid", cfg_valid, 1'b0);
      chk("rst_cfg",       cfg,       '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // commit with nothing written fails at field 0
      commit_wait(0, cyc, bcnt);
      chk("empty_latency",   cyc,       1);
      chk("empty_error",     error,     1'b1);
      chk("empty_err_field", err_field, 4'd0);
      chk("empty_cfg_valid", cfg_valid, 1'b0);
      chk("empty_cfg",       cfg,       '0);

      // small preset passes
      for (int i = 0; i < NF; i++) write_field(i, preset[i]);
      commit_wait(0, cyc, bcnt);
      chk("preset_latency",   cyc,        15);
      chk("preset_busy_cnt",  bcnt,       15);
      chk("preset_f0",        field(0),   16);
      chk("preset_f13",       field(13),  2);
      chk("preset_cfg_valid", cfg_valid,  1'b1);
      chk("preset_error",     error,      1'b0);

      // field 9 zeroed fails, active set kept
      write_field(9, 0);
      commit_wait(0, cyc, bcnt);
      chk("f9_latency",   cyc,       10);
      chk("f9_err_field", err_field, 4'd9);
      chk("f9_error",     error,     1'b1);
      chk("f9_keep_f7",   field(7),  256);
      chk("f9_cfg_valid", cfg_valid, 1'b1);

      // predictor type out of range, then fixed
      write_field(9, 512);
      write_field(13, 4);
      commit_wait(0, cyc, bcnt);
      chk("f13_latency",   cyc,       14);
      chk("f13_err_field", err_field, 4'd13);
      write_field(13, 3);
      commit_wait(0, cyc, bcnt);
      chk("f13fix_latency", cyc,       15);
      chk("f13fix_error",   error,     1'b0);
      chk("f13fix_f13",     field(13), 3);

      // writes and commits during CHECK are ignored
      commit_wait(1, cyc, bcnt);
      chk("noisy_latency", cyc,      15);
      chk("noisy_f9",      field(9), 512);
      repeat (3) @(posedge clk);
      #1;
      write_field(15, 0);
      write_field(14, 0);
      commit_wait(0, cyc, bcnt);
      chk("addr15_latency", cyc,      15);
      chk("addr15_f0",      field(0), 16);

      // async reset in the middle of CHECK
      commit = 1'b1;
      @(posedge clk);
      #1;
      commit = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",      busy,      1'b0);
      chk("midrst_wr_ready",  wr_ready,  1'b1);
      chk("midrst_cfg_valid", cfg_valid, 1'b0);
      chk("midrst_cfg",       cfg,       '0);
      chk("midrst_done",      done,      1'b0);
      chk("midrst_error",     error,     1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         a = 4'($urandom_range(0, 15));
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = a;
         if (a == 4'd13) wr_data = FW'($urandom_range(0, 5));
         else if ($urandom_range(0, 9) == 0) wr_data = '0;
         else wr_data = FW'($urandom_range(1, 65535));
         commit = ($urandom_range(0, 11) == 0);
         if (c == 1500) rst_n = 1'b0;
         if (c == 1503) rst_n = 1'b1;
         @(posedge clk);
         #1;
      end
      wr_valid = 1'b0;
      commit = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
